// File: rtl/seq_divider_pkg.sv
// Shared FSM encoding, parameter legality check and width-generic sign helpers
// for seq_divider (helpers operate on MAX_W bits; callers cast to WIDTH).
package seq_divider_pkg;

  localparam int MAX_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_e;

  function automatic bit cfg_legal(input int width, input int bpc);
    return (width >= 8) && (width <= MAX_W) && (width % 2 == 0) &&
           (bpc == 1 || bpc == 2 || bpc == 4) && (width % bpc == 0);
  endfunction

  function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] x,
                                                 input logic              neg);
    return neg ? negate(x) : x;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring division step: shift in a dividend bit, subtract if it fits.
// Latency: combinational. Backpressure: none (pure datapath).
module seq_divider_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             dividend_bit_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;

  // A set top bit means the shifted value already exceeds any WIDTH-bit divisor.
  assign shifted = {r_i[WIDTH-1:0], dividend_bit_i};
  assign q_bit_o = r_i[WIDTH] | (shifted >= {1'b0, divisor_i});
  assign r_o     = q_bit_o ? (shifted - {1'b0, divisor_i}) : shifted;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, BPC quotient bits/cycle; signed mode under SEQ_DIVIDER_SIGNED_EN.
// Latency: WIDTH/BPC+3 cycles accept->out_valid (divide-by-zero: 3); one division in flight.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BPC   = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_dbz,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int ITERS = WIDTH / BPC;
  localparam int CNT_W = $clog2(ITERS);

  if (!cfg_legal(WIDTH, BPC)) begin : g_bad_cfg
    $error("seq_divider: illegal WIDTH/BPC combination");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aq_q, aq_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  // aq_q starts as the dividend; quotient bits shift in at the bottom as dividend bits leave the top.
  logic [WIDTH:0]   r_chain [BPC+1];
  logic [BPC-1:0]   q_bits;

  assign r_chain[0] = r_q;

  for (genvar k = 0; k < BPC; k++) begin : g_step
    seq_divider_step #(.WIDTH(WIDTH)) u_step (
      .r_i            (r_chain[k]),
      .divisor_i      (b_q),
      .dividend_bit_i (aq_q[WIDTH-1-k]),
      .r_o            (r_chain[k+1]),
      .q_bit_o        (q_bits[BPC-1-k])
    );
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sgn_q, sgn_d;
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic neg_a, neg_b;

  assign neg_a = sgn_q & aq_q[WIDTH-1];
  assign neg_b = sgn_q & b_q[WIDTH-1];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = in_signed;
`endif

  assign in_ready      = (state_q == IDLE) && !arst;
  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign out_quotient  = quo_q;
  assign out_remainder = rem_q;
  assign out_dbz       = dbz_q;
  assign out_tag       = tag_q;

  always_comb begin
    state_d = state_q;
    aq_d    = aq_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    tag_d   = tag_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          aq_d    = in_dividend;
          b_d     = in_divisor;
          tag_d   = in_tag;
          dbz_d   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
          sgn_d   = in_signed;
`endif
          state_d = PREP;
        end
      end
      PREP: begin
        // On divide-by-zero aq_q keeps the raw dividend, which becomes the remainder.
        if (b_q == '0) begin
          dbz_d   = 1'b1;
          state_d = FIX;
        end else begin
          r_d     = '0;
          cnt_d   = CNT_W'(ITERS - 1);
          state_d = ITER;
`ifdef SEQ_DIVIDER_SIGNED_EN
          aq_d      = WIDTH'(magnitude(MAX_W'(aq_q), neg_a));
          b_d       = WIDTH'(magnitude(MAX_W'(b_q), neg_b));
          neg_quo_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
`endif
        end
      end
      ITER: begin
        r_d   = r_chain[BPC];
        aq_d  = {aq_q[WIDTH-BPC-1:0], q_bits};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dbz_q) begin
          quo_d = '1;
          rem_d = aq_q;
        end else begin
          quo_d = aq_q;
          rem_d = r_q[WIDTH-1:0];
`ifdef SEQ_DIVIDER_SIGNED_EN
          if (neg_quo_q) quo_d = WIDTH'(negate(MAX_W'(aq_q)));
          if (neg_rem_q) rem_d = WIDTH'(negate(MAX_W'(r_q[WIDTH-1:0])));
`endif
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      aq_q    <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      tag_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      aq_q    <= aq_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      tag_q   <= tag_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a W=64/BPC=1 instance and a W=32/BPC=4 instance.
// Expected results follow the signed or unsigned build depending on SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [3:0]  tag;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  vec_t sb_b[$];
  vec_t mon_e;
  vec_t vt[12];

  logic [63:0] a_in_dividend = '0, a_in_divisor = '0;
  logic        a_in_signed = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic [3:0]  a_in_tag = '0;
  logic        a_in_ready, a_out_dbz, a_out_valid, a_busy;
  logic [63:0] a_out_quotient, a_out_remainder;
  logic [3:0]  a_out_tag;

  logic [31:0] b_in_dividend = '0, b_in_divisor = '0;
  logic        b_in_signed = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [3:0]  b_in_tag = '0;
  logic        b_in_ready, b_out_dbz, b_out_valid, b_busy;
  logic [31:0] b_out_quotient, b_out_remainder;
  logic [3:0]  b_out_tag;

  seq_divider #(.WIDTH(64), .BPC(1), .TAG_W(4)) u_dut_a (
    .clk(clk), .arst(arst),
    .in_dividend(a_in_dividend), .in_divisor(a_in_divisor), .in_signed(a_in_signed),
    .in_tag(a_in_tag), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_quotient(a_out_quotient), .out_remainder(a_out_remainder), .out_dbz(a_out_dbz),
    .out_tag(a_out_tag), .out_valid(a_out_valid), .out_ready(a_out_ready), .busy(a_busy)
  );

  seq_divider #(.WIDTH(32), .BPC(4), .TAG_W(4)) u_dut_b (
    .clk(clk), .arst(arst),
    .in_dividend(b_in_dividend), .in_divisor(b_in_divisor), .in_signed(b_in_signed),
    .in_tag(b_in_tag), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_quotient(b_out_quotient), .out_remainder(b_out_remainder), .out_dbz(b_out_dbz),
    .out_tag(b_out_tag), .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model built on the simulator's own division operators.
  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic sg, input logic [3:0] tg);
    vec_t   v;
    longint sa, sb;
    v.a = a; v.b = b; v.sg = sg; v.tag = tg;
    if (b == '0) begin
      v.q = '1; v.r = a; v.dbz = 1'b1; v.lat = 3;
    end else begin
      v.dbz = 1'b0; v.lat = 11;
      if (sg && SGN_EN) begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        v.q = 32'(sa / sb);
        v.r = 32'(sa % sb);
      end else begin
        v.q = a / b;
        v.r = a % b;
      end
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (!arst && b_out_valid && b_out_ready) begin
      if (sb_b.size() == 0) begin
        check("b_unexpected_result", b_out_valid, 1'b0);
      end else begin
        mon_e = sb_b.pop_front();
        check("b_quotient", b_out_quotient, mon_e.q);
        check("b_remainder", b_out_remainder, mon_e.r);
        check("b_dbz", b_out_dbz, mon_e.dbz);
        check("b_tag", b_out_tag, mon_e.tag);
      end
    end
  end

  task automatic send_b(input vec_t v, output int acc);
    int n = 0;
    b_in_dividend = v.a; b_in_divisor = v.b; b_in_signed = v.sg; b_in_tag = v.tag;
    b_in_valid = 1'b1;
    while (!b_in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) check("b_accept_timeout", b_in_ready, 1'b1);
    @(posedge clk); #1;
    acc = cyc;
    b_in_valid = 1'b0;
  endtask

  task automatic wait_valid_b(input int lat, input int acc);
    int n = 0;
    while (!b_out_valid && n < 300) begin @(posedge clk); #1; n++; end
    check("b_latency", cyc - acc + 1, lat);
  endtask

  task automatic drain_b();
    int n = 0;
    while (b_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) check("b_drain_timeout", b_out_valid, 1'b0);
  endtask

  task automatic run_vec_b(input vec_t v);
    int acc;
    send_b(v, acc);
    sb_b.push_back(v);
    wait_valid_b(v.lat, acc);
    drain_b();
  endtask

  task automatic run_a(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tg,
                       input logic [63:0] eq, input logic [63:0] er);
    int n = 0;
    int acc;
    a_in_dividend = a; a_in_divisor = b; a_in_tag = tg; a_in_valid = 1'b1;
    while (!a_in_ready && n < 300) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    acc = cyc;
    a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 300) begin @(posedge clk); #1; n++; end
    check("a_latency", cyc - acc + 1, 67);
    check("a_quotient", a_out_quotient, eq);
    check("a_remainder", a_out_remainder, er);
    check("a_dbz", a_out_dbz, 1'b0);
    check("a_tag", a_out_tag, tg);
    @(posedge clk); #1;
    check("a_handshake_done", a_out_valid, 1'b0);
  endtask

  initial begin
    vec_t        v1, v2;
    int          acc, rel, vcnt;
    logic [31:0] ra, rb;

    vt[0]  = '{32'hFFFFFFF9, 32'd2, 1'b1, 4'd1, SGN_EN ? 32'hFFFFFFFD : 32'h7FFFFFFC,
               SGN_EN ? 32'hFFFFFFFF : 32'h1, 1'b0, 11};
    vt[1]  = '{32'd7, 32'hFFFFFFFE, 1'b1, 4'd2, SGN_EN ? 32'hFFFFFFFD : 32'h0,
               SGN_EN ? 32'h1 : 32'h7, 1'b0, 11};
    vt[2]  = '{32'h1234, 32'h0, 1'b0, 4'd5, 32'hFFFFFFFF, 32'h1234, 1'b1, 3};
    vt[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 4'd6, SGN_EN ? 32'h80000000 : 32'h0,
               SGN_EN ? 32'h0 : 32'h80000000, 1'b0, 11};
    vt[4]  = '{32'd1000, 32'd10, 1'b0, 4'd7, 32'd100, 32'd0, 1'b0, 11};
    vt[5]  = '{32'hFFFFFFFF, 32'd1, 1'b0, 4'd8, 32'hFFFFFFFF, 32'd0, 1'b0, 11};
    vt[6]  = '{32'd5, 32'd9, 1'b0, 4'd0, 32'd0, 32'd5, 1'b0, 11};
    vt[7]  = '{32'hFFFFFF9C, 32'd7, 1'b1, 4'd9, SGN_EN ? 32'hFFFFFFF2 : 32'h24924916,
               SGN_EN ? 32'hFFFFFFFE : 32'h2, 1'b0, 11};
    vt[8]  = '{32'hFFFFFFF0, 32'hFFFFFFFC, 1'b1, 4'hA, SGN_EN ? 32'h4 : 32'h0,
               SGN_EN ? 32'h0 : 32'hFFFFFFF0, 1'b0, 11};
    vt[9]  = '{32'hFFFFFFFB, 32'h0, 1'b1, 4'hB, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 3};
    vt[10] = '{32'hDEADBEEF, 32'h10, 1'b0, 4'hC, 32'h0DEADBEE, 32'hF, 1'b0, 11};
    vt[11] = '{32'd100, 32'd7, 1'b1, 4'hD, 32'd14, 32'd2, 1'b0, 11};

    #1 arst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready_a", a_in_ready, 1'b0);
    check("rst_in_ready_b", b_in_ready, 1'b0);
    check("rst_busy_b", b_busy, 1'b0);
    check("rst_valid_b", b_out_valid, 1'b0);
    check("rst_quotient_a", a_out_quotient, 64'd0);
    check("rst_remainder_b", b_out_remainder, 32'd0);
    check("rst_tag_b", b_out_tag, 4'd0);
    check("rst_dbz_b", b_out_dbz, 1'b0);
    arst = 1'b0;
    #1;
    check("post_rst_in_ready_a", a_in_ready, 1'b1);
    check("post_rst_in_ready_b", b_in_ready, 1'b1);
    check("post_rst_busy_a", a_busy, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec_b(vt[i]);

    run_a(64'd100, 64'd7, 4'd3, 64'd14, 64'd2);
    run_a(64'hFFFFFFFFFFFFFFFF, 64'd3, 4'hF, 64'h5555555555555555, 64'd0);
    run_a(64'h8000000000000001, 64'h100000000, 4'h9, 64'h80000000, 64'd1);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom();
      rb = $urandom() >> $urandom_range(0, 31);
      if (i % 8 == 5) rb = '0;
      run_vec_b(mk(ra, rb, 1'($urandom_range(0, 1)), 4'(i)));
    end

    // Back-pressure: result held, second request waits for handshake + one IDLE cycle.
    b_out_ready = 1'b0;
    v1 = mk(32'h12345678, 32'h1000, 1'b0, 4'h4);
    v2 = mk(32'd9999, 32'd100, 1'b0, 4'h6);
    send_b(v1, acc);
    sb_b.push_back(v1);
    wait_valid_b(11, acc);
    b_in_dividend = v2.a; b_in_divisor = v2.b; b_in_signed = v2.sg; b_in_tag = v2.tag;
    b_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", b_out_valid, 1'b1);
      check("bp_in_ready", b_in_ready, 1'b0);
      check("bp_result_stable", {b_out_quotient, b_out_remainder}, {v1.q, v1.r});
    end
    b_out_ready = 1'b1;
    rel = cyc;
    send_b(v2, acc);
    check("bp_accept_cycle", acc - rel, 2);
    sb_b.push_back(v2);
    wait_valid_b(v2.lat, acc);
    drain_b();

    // Reset mid-ITER aborts the request without emitting anything.
    v1 = mk(32'd1000, 32'd3, 1'b0, 4'hE);
    send_b(v1, acc);
    repeat (4) @(posedge clk);
    #1;
    check("abort_pre_busy", b_busy, 1'b1);
    arst = 1'b1;
    #2;
    check("abort_busy", b_busy, 1'b0);
    check("abort_in_ready", b_in_ready, 1'b0);
    check("abort_tag", b_out_tag, 4'd0);
    check("abort_valid", b_out_valid, 1'b0);
    @(negedge clk);
    arst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b_out_valid) vcnt++;
    end
    check("abort_no_result", vcnt, 0);
    v1 = '{32'd50, 32'd5, 1'b0, 4'h1, 32'd10, 32'd0, 1'b0, 11};
    run_vec_b(v1);

    check("sb_b_leftover", sb_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
